// File: rtl/matmul_sequencer_pkg.sv
// Shared definitions for the matmul sequencer slice.
//   - FSM state encoding
//   - array geometry (N_DIM, skew padding) and datapath pipeline latency
//   - default widths for instruction, K and column address fields
package matmul_pkg;

  localparam int N_DIM       = 4;
  // Pre-skewed operands need 2*(N_DIM-1) extra columns beyond K.
  localparam int SKEW        = 2 * (N_DIM - 1);
  // Memory read register + PE register between last column read and last PE update.
  localparam int PIPE_LAT    = 2;

  localparam int INST_AW_DEF = 3;
  localparam int K_W_DEF     = 4;
  localparam int COL_AW_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_CLEAR,
    ST_STREAM,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/matmul_sequencer_if.sv
// Host/memory-side signal bundle of the matmul sequencer.
//   master : the sequencer (drives strobes, addresses and status)
//   slave  : host + memories (drive ap_start and the registered instruction word)
// Signals:
//   ap_start / ap_done / busy / err_col_ovf / done_count : host control and status
//   inst_rd_en / inst_addr / inst_data                   : instruction memory port
//   in_rd_en / in_col_addr                               : shared A/B input memory port
//   arr_clr                                              : PE accumulator clear
//   out_wr_en / out_slot                                 : output memory capture
interface matmul_sequencer_if
  import matmul_pkg::*;
#(
  parameter int INST_AW = INST_AW_DEF,
  parameter int K_W     = K_W_DEF,
  parameter int COL_AW  = COL_AW_DEF
) ();

  logic               ap_start;
  logic               ap_done;
  logic               busy;
  logic               err_col_ovf;
  logic [INST_AW:0]   done_count;
  logic               inst_rd_en;
  logic [INST_AW-1:0] inst_addr;
  logic [K_W-1:0]     inst_data;
  logic               in_rd_en;
  logic [COL_AW-1:0]  in_col_addr;
  logic               arr_clr;
  logic               out_wr_en;
  logic [INST_AW-1:0] out_slot;

  modport master (
    input  ap_start, inst_data,
    output ap_done, busy, err_col_ovf, done_count, inst_rd_en, inst_addr,
           in_rd_en, in_col_addr, arr_clr, out_wr_en, out_slot
  );

  modport slave (
    output ap_start, inst_data,
    input  ap_done, busy, err_col_ovf, done_count, inst_rd_en, inst_addr,
           in_rd_en, in_col_addr, arr_clr, out_wr_en, out_slot
  );

endinterface

// File: rtl/matmul_col_counter.sv
// Loadable down-counter plus column address generator used for STREAM and DRAIN.
//   load/load_val : reload remaining-cycle count (priority over dec)
//   dec           : count down by one
//   tc            : remaining count is 1, i.e. this is the last cycle of the phase
//   addr_load     : load column address from addr_base
//   addr_inc      : advance column address by one
//   addr          : current column address (holds when neither load nor inc)
module matmul_col_counter #(
  parameter int CNT_W  = 9,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [CNT_W-1:0]  load_val,
  input  logic              dec,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_base,
  input  logic              addr_inc,
  output logic              tc,
  output logic [ADDR_W-1:0] addr
);

  logic [CNT_W-1:0] rem;

  assign tc = (rem == CNT_W'(1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem  <= '0;
      addr <= '0;
    end else begin
      if (load)     rem <= load_val;
      else if (dec) rem <= rem - CNT_W'(1);

      if (addr_load)     addr <= addr_base;
      else if (addr_inc) addr <= addr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/matmul_sequencer.sv
// Control FSM sequencing the 4x4 systolic matmul datapath over a job list.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : matmul_sequencer_if.master (host control, instruction memory,
//              input memories, PE clear, output memory capture)
// Each non-zero instruction K runs FETCH, DECODE, CLEAR, STREAM (K+skew cycles),
// DRAIN (PIPE_LAT cycles) and WRITE; a zero instruction, a column-space overflow
// or the last table entry ends the job in DONE.
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int INST_AW = INST_AW_DEF,
  parameter int K_W     = K_W_DEF,
  parameter int COL_AW  = COL_AW_DEF
) (
  input logic                clk,
  input logic                rst,
  matmul_sequencer_if.master bus
);

  localparam int LEN_W = COL_AW + 1;
  // One extra bit so col_base + len never wraps before the limit compare.
  localparam int SUM_W = COL_AW + 2;
  localparam logic [INST_AW-1:0] PC_LAST = '1;

  state_t             state, state_nxt;
  logic [INST_AW-1:0] pc;
  logic [LEN_W-1:0]   col_base;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   len_nxt;
  logic [INST_AW:0]   done_count_q;
  logic               err_q;
  logic [INST_AW-1:0] out_slot_q;
  logic               start_acc;
  logic               inst_zero;
  logic               ovf;
  logic               cnt_load;
  logic [LEN_W-1:0]   cnt_load_val;
  logic               cnt_dec;
  logic               cnt_tc;
  logic               addr_load;
  logic               addr_inc;
  logic [COL_AW-1:0]  col_addr;

  assign start_acc = ((state == ST_IDLE) || (state == ST_DONE)) && bus.ap_start;
  assign inst_zero = (bus.inst_data == '0);
  assign len_nxt   = LEN_W'(bus.inst_data) + LEN_W'(SKEW);
  assign ovf       = (SUM_W'(col_base) + SUM_W'(len_nxt)) > SUM_W'(2 ** COL_AW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE,
      ST_DONE:   if (bus.ap_start) state_nxt = ST_FETCH;
      ST_FETCH:  state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = (inst_zero || ovf) ? ST_DONE : ST_CLEAR;
      ST_CLEAR:  state_nxt = ST_STREAM;
      ST_STREAM: if (cnt_tc) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (cnt_tc) state_nxt = ST_WRITE;
      ST_WRITE:  state_nxt = (pc == PC_LAST) ? ST_DONE : ST_FETCH;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would infer a latch.
  always_comb begin
    bus.inst_rd_en = 1'b0;
    bus.arr_clr    = 1'b0;
    bus.in_rd_en   = 1'b0;
    bus.out_wr_en  = 1'b0;
    bus.busy       = 1'b0;
    bus.ap_done    = 1'b0;
    cnt_load       = 1'b0;
    cnt_load_val   = '0;
    cnt_dec        = 1'b0;
    addr_load      = 1'b0;
    addr_inc       = 1'b0;
    unique case (state)
      ST_FETCH: begin
        bus.inst_rd_en = 1'b1;
        bus.busy       = 1'b1;
      end
      ST_DECODE: bus.busy = 1'b1;
      ST_CLEAR: begin
        bus.arr_clr  = 1'b1;
        bus.busy     = 1'b1;
        cnt_load     = 1'b1;
        cnt_load_val = len_q;
        addr_load    = 1'b1;
      end
      ST_STREAM: begin
        bus.in_rd_en = 1'b1;
        bus.busy     = 1'b1;
        // Last column: reuse the counter for the drain wait; address stays put.
        if (cnt_tc) begin
          cnt_load     = 1'b1;
          cnt_load_val = LEN_W'(PIPE_LAT);
        end else begin
          cnt_dec  = 1'b1;
          addr_inc = 1'b1;
        end
      end
      ST_DRAIN: begin
        bus.busy = 1'b1;
        cnt_dec  = 1'b1;
      end
      ST_WRITE: begin
        bus.out_wr_en = 1'b1;
        bus.busy      = 1'b1;
      end
      ST_DONE: bus.ap_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= '0;
      col_base     <= '0;
      len_q        <= '0;
      done_count_q <= '0;
      err_q        <= 1'b0;
      out_slot_q   <= '0;
    end else begin
      if (start_acc) begin
        pc           <= '0;
        col_base     <= '0;
        done_count_q <= '0;
        err_q        <= 1'b0;
      end
      if ((state == ST_DECODE) && !inst_zero) begin
        len_q <= len_nxt;
        if (ovf) err_q <= 1'b1;
      end
      // Captured on entry to WRITE so out_slot holds while pc moves on.
      if ((state == ST_DRAIN) && cnt_tc) out_slot_q <= pc;
      if (state == ST_WRITE) begin
        col_base     <= col_base + len_q;
        done_count_q <= done_count_q + 1'b1;
        if (pc != PC_LAST) pc <= pc + 1'b1;
      end
    end
  end

  matmul_col_counter #(
    .CNT_W (LEN_W),
    .ADDR_W(COL_AW)
  ) u_col_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .addr_load(addr_load),
    .addr_base(col_base[COL_AW-1:0]),
    .addr_inc (addr_inc),
    .tc       (cnt_tc),
    .addr     (col_addr)
  );

  assign bus.inst_addr   = pc;
  assign bus.in_col_addr = col_addr;
  assign bus.out_slot    = out_slot_q;
  assign bus.done_count  = done_count_q;
  assign bus.err_col_ovf = err_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: two instances (COL_AW=8 and COL_AW=7) share clk/rst.
// Expected per-cycle behaviour comes from a job-level timeline model computed
// from the instruction list with plain arithmetic.
module tb_matmul_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matmul_sequencer_if #(.INST_AW(3), .K_W(4), .COL_AW(8)) bus8 ();
  matmul_sequencer_if #(.INST_AW(3), .K_W(4), .COL_AW(7)) bus7 ();

  matmul_sequencer #(.INST_AW(3), .K_W(4), .COL_AW(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  matmul_sequencer #(.INST_AW(3), .K_W(4), .COL_AW(7)) dut7 (.clk(clk), .rst(rst), .bus(bus7));

  logic [3:0] imem8 [8];
  logic [3:0] imem7 [8];

  // Registered instruction memories.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus8.inst_data <= '0;
      bus7.inst_data <= '0;
    end else begin
      if (bus8.inst_rd_en) bus8.inst_data <= imem8[bus8.inst_addr];
      if (bus7.inst_rd_en) bus7.inst_data <= imem7[bus7.inst_addr];
    end
  end

  int checks   = 0;
  int failures = 0;

  // Expected per-cycle vector, cycle 1 = first cycle after the ap_start edge.
  logic [24:0] exp_vec [256];
  int          model_done_t;
  int          model_count;
  bit          model_err;

  // Strobe-qualified view: addresses only matter while their strobe is high.
  function automatic logic [24:0] obs_vec(input bit sel);
    logic [7:0] col;
    if (sel) begin
      col = {1'b0, bus7.in_col_addr};
      return {bus7.inst_rd_en, bus7.inst_rd_en ? bus7.inst_addr : 3'd0,
              bus7.arr_clr, bus7.in_rd_en, bus7.in_rd_en ? col : 8'd0,
              bus7.out_wr_en, bus7.out_wr_en ? bus7.out_slot : 3'd0,
              bus7.ap_done, bus7.busy, bus7.done_count, bus7.err_col_ovf};
    end
    return {bus8.inst_rd_en, bus8.inst_rd_en ? bus8.inst_addr : 3'd0,
            bus8.arr_clr, bus8.in_rd_en, bus8.in_rd_en ? bus8.in_col_addr : 8'd0,
            bus8.out_wr_en, bus8.out_wr_en ? bus8.out_slot : 3'd0,
            bus8.ap_done, bus8.busy, bus8.done_count, bus8.err_col_ovf};
  endfunction

  // Unqualified view of every output, for the all-zero reset checks.
  function automatic logic [24:0] raw_vec(input bit sel);
    if (sel)
      return {bus7.inst_rd_en, bus7.inst_addr, bus7.arr_clr, bus7.in_rd_en,
              1'b0, bus7.in_col_addr, bus7.out_wr_en, bus7.out_slot,
              bus7.ap_done, bus7.busy, bus7.done_count, bus7.err_col_ovf};
    return {bus8.inst_rd_en, bus8.inst_addr, bus8.arr_clr, bus8.in_rd_en,
            bus8.in_col_addr, bus8.out_wr_en, bus8.out_slot,
            bus8.ap_done, bus8.busy, bus8.done_count, bus8.err_col_ovf};
  endfunction

  // Job timeline: each product occupies K+12 cycles starting at its fetch;
  // a zero entry or an overflowing product ends two cycles after its fetch.
  task automatic build_model(input bit sel);
    bit       fetch [256];
    int       iaddr [256];
    bit       clr   [256];
    bit       rd    [256];
    int       col   [256];
    bit       wr    [256];
    int       slot  [256];
    int       wtimes[$];
    int       t, pc, base, k, len, w, lim, cnt;
    bit       fin;
    for (int c = 0; c < 256; c++) begin
      fetch[c] = 0; iaddr[c] = 0; clr[c] = 0; rd[c] = 0;
      col[c] = 0; wr[c] = 0; slot[c] = 0;
    end
    lim = sel ? 128 : 256;
    t = 1; pc = 0; base = 0; model_err = 0; fin = 0;
    while (!fin) begin
      fetch[t] = 1;
      iaddr[t] = pc;
      k = int'(sel ? imem7[pc] : imem8[pc]);
      len = k + 6;
      if (k == 0) begin
        model_done_t = t + 2;
        fin = 1;
      end else if (base + len > lim) begin
        model_err = 1;
        model_done_t = t + 2;
        fin = 1;
      end else begin
        clr[t + 2] = 1;
        for (int i = 0; i < len; i++) begin
          rd[t + 3 + i]  = 1;
          col[t + 3 + i] = base + i;
        end
        w = t + 3 + len + 2;
        wr[w]   = 1;
        slot[w] = pc;
        wtimes.push_back(w);
        base += len;
        if (pc == 7) begin
          model_done_t = w + 1;
          fin = 1;
        end else begin
          pc++;
          t = w + 1;
        end
      end
    end
    model_count = wtimes.size();
    for (int c = 0; c < 256; c++) begin
      cnt = 0;
      foreach (wtimes[j]) if (wtimes[j] < c) cnt++;
      exp_vec[c] = {fetch[c], 3'(iaddr[c]), clr[c], rd[c], 8'(col[c]),
                    wr[c], 3'(slot[c]),
                    (c >= model_done_t), (c < model_done_t),
                    4'(cnt), (model_err && (c >= model_done_t))};
    end
  endtask

  task automatic drive_start(input bit sel, input logic v);
    if (sel) bus7.ap_start = v;
    else     bus8.ap_start = v;
  endtask

  // Pulse ap_start, then compare every cycle until two cycles past DONE.
  // repulse > 0 re-raises ap_start for one cycle at that cycle number.
  task automatic run_job(input bit sel, input int repulse, input string name);
    logic [24:0] o;
    build_model(sel);
    @(posedge clk); #1 drive_start(sel, 1'b1);
    @(posedge clk); #1 drive_start(sel, 1'b0);
    for (int c = 1; c <= model_done_t + 2; c++) begin
      @(negedge clk);
      o = obs_vec(sel);
      checks++;
      if (o !== exp_vec[c]) begin
        failures++;
        $display("FAIL %s cycle %0d: got %h want %h", name, c, o, exp_vec[c]);
      end
      if (repulse > 0 && c == repulse)     drive_start(sel, 1'b1);
      if (repulse > 0 && c == repulse + 1) drive_start(sel, 1'b0);
    end
  endtask

  task automatic load_mem(input bit sel, input int k0, input int k1, input int k2,
                          input int k3, input int rest);
    logic [3:0] v [8];
    v[0] = 4'(k0); v[1] = 4'(k1); v[2] = 4'(k2); v[3] = 4'(k3);
    for (int i = 4; i < 8; i++) v[i] = 4'(rest);
    for (int i = 0; i < 8; i++) begin
      if (sel) imem7[i] = v[i];
      else     imem8[i] = v[i];
    end
  endtask

  task automatic test_reset();
    bus8.ap_start = 1'b0;
    bus7.ap_start = 1'b0;
    rst = 1'b1;
    #3;
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (raw_vec(s[0]) !== 25'd0) begin
        failures++;
        $display("FAIL reset_outputs dut%0d: got %h want 0", s, raw_vec(s[0]));
      end
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    load_mem(0, 4, 0, 0, 0, 0);
    run_job(0, 0, "single");
  endtask

  task automatic test_three();
    load_mem(0, 2, 4, 1, 0, 0);
    run_job(0, 0, "three");
    checks++;
    if (bus8.done_count !== 4'd3 || bus8.err_col_ovf !== 1'b0) begin
      failures++;
      $display("FAIL three_final: got count=%0d err=%b want count=3 err=0",
               bus8.done_count, bus8.err_col_ovf);
    end
  endtask

  task automatic test_empty();
    load_mem(0, 0, 3, 3, 3, 3);
    run_job(0, 0, "empty");
  endtask

  task automatic test_full_table();
    load_mem(0, 15, 15, 15, 15, 15);
    run_job(0, 0, "full_table");
    checks++;
    if (bus8.done_count !== 4'd8 || bus8.in_col_addr !== 8'd167) begin
      failures++;
      $display("FAIL full_table_final: got count=%0d last_col=%0d want count=8 last_col=167",
               bus8.done_count, bus8.in_col_addr);
    end
  endtask

  task automatic test_overflow();
    load_mem(1, 15, 15, 15, 15, 15);
    run_job(1, 0, "overflow");
    checks++;
    if (bus7.done_count !== 4'd6 || bus7.err_col_ovf !== 1'b1) begin
      failures++;
      $display("FAIL overflow_final: got count=%0d err=%b want count=6 err=1",
               bus7.done_count, bus7.err_col_ovf);
    end
  endtask

  task automatic test_start_mid_stream();
    load_mem(0, 2, 4, 1, 0, 0);
    run_job(0, 6, "start_mid_stream");
  endtask

  task automatic test_reset_mid_drain();
    logic [24:0] r;
    load_mem(0, 4, 0, 0, 0, 0);
    @(posedge clk); #1 bus8.ap_start = 1'b1;
    @(posedge clk); #1 bus8.ap_start = 1'b0;
    for (int c = 1; c <= 14; c++) @(negedge clk);
    // Cycle 14 is the first DRAIN cycle of a K=4 product.
    checks++;
    if (bus8.busy !== 1'b1 || bus8.in_rd_en !== 1'b0 || bus8.out_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL drain_state: got busy=%b rd=%b wr=%b want 1 0 0",
               bus8.busy, bus8.in_rd_en, bus8.out_wr_en);
    end
    #1 rst = 1'b1;
    #1 r = raw_vec(0);
    checks++;
    if (r !== 25'd0) begin
      failures++;
      $display("FAIL reset_mid_drain: got %h want 0", r);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (bus8.out_wr_en !== 1'b0 || bus8.busy !== 1'b0 || bus8.ap_done !== 1'b0) begin
        failures++;
        $display("FAIL post_reset_idle: got wr=%b busy=%b done=%b want 0 0 0",
                 bus8.out_wr_en, bus8.busy, bus8.ap_done);
      end
    end
  endtask

  task automatic test_rerun_after_reset();
    load_mem(0, 4, 0, 0, 0, 0);
    run_job(0, 0, "rerun_after_reset");
  endtask

  task automatic test_restart_from_done();
    load_mem(0, 2, 4, 1, 0, 0);
    run_job(0, 0, "restart_first");
    checks++;
    if (bus8.ap_done !== 1'b1 || bus8.done_count !== 4'(model_count)) begin
      failures++;
      $display("FAIL restart_pre: got done=%b count=%0d want done=1 count=%0d",
               bus8.ap_done, bus8.done_count, model_count);
    end
    run_job(0, 0, "restart_replay");
  endtask

  task automatic test_random();
    int n;
    for (int j = 0; j < 6; j++) begin
      bit sel;
      sel = (j >= 4);
      n = $urandom_range(0, 8);
      for (int i = 0; i < 8; i++) begin
        logic [3:0] v;
        v = (i < n) ? 4'($urandom_range(1, 15)) : 4'd0;
        if (sel) imem7[i] = v;
        else     imem8[i] = v;
      end
      run_job(sel, 0, sel ? "random_col7" : "random_col8");
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      imem8[i] = '0;
      imem7[i] = '0;
    end
    test_reset();
    test_single();
    test_three();
    test_empty();
    test_full_table();
    test_overflow();
    test_start_mid_stream();
    test_reset_mid_drain();
    test_rerun_after_reset();
    test_restart_from_done();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
